// File: rtl/sar_search_pkg.sv
// Shared types for the successive-approximation search engine: FSM state
// encoding and the bit-index counter width helper.
package sar_search_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } sar_state_t;

  // Bit-index counter width; a 1-bit word still needs a 1-bit counter.
  function automatic int sar_idx_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search: recovers an unknown word MSB first by
// probing an external magnitude comparator. Optional: SAR_SEARCH_EQ_EARLY_EXIT_EN.
// Handshake: start is accepted only in IDLE; done is a one-cycle pulse with
// result valid, and result holds until the next accepted start.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int word_width = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  above,
  input  logic                  below,
  output logic [word_width-1:0] probe,
  output logic                  busy,
  output logic                  done,
  output logic [word_width-1:0] result,
  output logic                  error,
  output sar_state_t            state_o
);

  localparam int IW = sar_idx_width(word_width);

  sar_state_t            state_q, state_d;
  logic [word_width-1:0] probe_q, probe_d;
  logic [word_width-1:0] result_q, result_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  error_q, error_d;

  logic [word_width-1:0] bit_mask;
  logic [word_width-1:0] decided;
  logic                  eq_exit;

  always_comb begin
    bit_mask = word_width'(1) << idx_q;
    // below alone or both high both clear the trial bit
    decided  = below ? (probe_q & ~bit_mask) : probe_q;
`ifdef SAR_SEARCH_EQ_EARLY_EXIT_EN
    eq_exit  = ~above & ~below;
`else
    eq_exit  = 1'b0;
`endif
  end

  always_comb begin
    state_d  = state_q;
    probe_d  = probe_q;
    result_d = result_q;
    idx_d    = idx_q;
    error_d  = error_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEARCH;
          probe_d = word_width'(1) << (word_width - 1);
          idx_d   = IW'(word_width - 1);
          error_d = 1'b0;
        end
      end
      SEARCH: begin
        error_d = error_q | (above & below);
        if (eq_exit) begin
          result_d = probe_q;
          state_d  = DONE;
        end else if (idx_q == '0) begin
          result_d = decided;
          state_d  = DONE;
        end else begin
          probe_d = decided | (bit_mask >> 1);
          idx_d   = idx_q - IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      probe_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      error_q  <= error_d;
    end
  end

  assign probe   = probe_q;
  assign result  = result_q;
  assign error   = error_q;
  assign busy    = (state_q == SEARCH);
  assign done    = (state_q == DONE);
  assign state_o = state_q;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search with a behavioural comparator; table vectors, random
// targets checked against a bit-by-bit search model, and hand-written corners.
module tb_sar_search;
  import sar_search_pkg::*;

  localparam int W = 8;
`ifdef SAR_SEARCH_EQ_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         above;
  logic         below;
  logic [W-1:0] probe;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         error;
  sar_state_t   state_o;

  logic [W-1:0] target;
  logic         force_both;

  int errors;
  int checks;

  // comparator: A = target, B = probe, with an override forcing both high
  assign above = force_both | (target > probe);
  assign below = force_both | (target < probe);

  sar_search #(.word_width(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .above   (above),
    .below   (below),
    .probe   (probe),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .error   (error),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- driver + model ----------------
  // Model: walk bits MSB first; trial = known bits | current bit; keep the
  // bit when target >= trial, unless the comparator is forced to "both".
  task automatic run_search(input logic [W-1:0] tgt, input int force_step,
                            input int pulse_step, output logic [W-1:0] res_o);
    logic [W-1:0] acc;
    logic [W-1:0] trial;
    bit           exp_err;
    bit           exited;
    bit           fb;
    int           step;
    acc = '0; exp_err = 1'b0; exited = 1'b0;
    target = tgt;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("error_cleared_by_start", error, 0);
    for (int b = W - 1; b >= 0 && !exited; b--) begin
      step  = W - 1 - b;
      trial = acc | (W'(1) << b);
      chk($sformatf("probe_step%0d", step), probe, trial);
      fb = (step == force_step);
      force_both = fb;
      start = (step == pulse_step);
      if (fb) exp_err = 1'b1;
      else if (EE && tgt == trial) begin acc = trial; exited = 1'b1; end
      else if (tgt >= trial) acc = trial;
      @(negedge clk);
      force_both = 1'b0;
      start = 1'b0;
      if (!exited && b > 0) chk($sformatf("busy_step%0d", step), busy, 1);
      chk($sformatf("error_step%0d", step), error, exp_err);
    end
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 0);
    chk("result_at_done", result, acc);
    chk("error_at_done", error, exp_err);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_not_busy", busy, 0);
    chk("result_held", result, acc);
    chk("error_sticky", error, exp_err);
    res_o = acc;
  endtask

  typedef struct {
    logic [W-1:0] tgt;
    int           force_step;
    int           pulse_step;
    logic [W-1:0] exp_res;
    logic         exp_err;
  } vec_t;

  vec_t         vecs[7];
  logic [W-1:0] res;
  int           cyc;

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; start = 1'b0; target = '0; force_both = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_probe", probe, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_state", state_o, IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // target, force step (-1 none), start pulse step (-1 none), result, error
    vecs[0] = '{8'd0,   -1, -1, 8'd0,   1'b0};
    vecs[1] = '{8'd255, -1, -1, 8'd255, 1'b0};
    vecs[2] = '{8'd100, -1, -1, 8'd100, 1'b0};
    vecs[3] = '{8'd100, -1,  3, 8'd100, 1'b0};
    vecs[4] = '{8'd100,  2, -1, 8'd95,  1'b1};
    vecs[5] = '{8'd37,  -1, -1, 8'd37,  1'b0};
    vecs[6] = '{8'd200, -1,  0, 8'd200, 1'b0};
    for (int i = 0; i < 7; i++) begin
      run_search(vecs[i].tgt, vecs[i].force_step, vecs[i].pulse_step, res);
      chk($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
      chk($sformatf("vec%0d_error", i), error, vecs[i].exp_err);
    end

    // randomized targets, occasionally with a forced "both" compare
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] t;
      int fs;
      t  = W'($urandom_range(0, 255));
      fs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      run_search(t, fs, -1, res);
      if (fs < 0) chk($sformatf("rand%0d_equals_target", i), result, t);
    end

    // reset asserted just before compare edge 4 aborts the search
    target = 8'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_probe", probe, 0);
    chk("abort_result", result, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_error", error, 0);
    chk("abort_state", state_o, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end

    // back-to-back with start held high: 37 then 200
    target = 8'd37; start = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!done && cyc < 20) begin @(negedge clk); cyc++; end
    chk("b2b_first_done_seen", done, 1);
    chk("b2b_first_result", result, 37);
    target = 8'd200;
    @(negedge clk);
    chk("b2b_idle_gap_busy", busy, 0);
    chk("b2b_idle_gap_done", done, 0);
    @(negedge clk);
    chk("b2b_second_busy", busy, 1);
    cyc = 0;
    while (!done && cyc < 20) begin @(negedge clk); cyc++; end
    chk("b2b_second_done_seen", done, 1);
    chk("b2b_second_result", result, 200);
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
